latch_test_sequencer: RTL and testbench

Self-checking stimulus controller for the positive/negative latch pair. On `start` it sequences both latches through a pseudo-random series of transparency and hold checks, compares the latch outputs against expected values, and reports a pass/fail summary. It sits between the chip-level control inputs and the latch datapath. It owns the latch `e`/`d` pins and observes the `q` pins.

---
 rtl/latch_test_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_latch_test_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_test_sequencer.sv
// Stimulus/check sequencer for a positive/negative latch pair: walks an LFSR
// vector series through open, close and hold phases and tallies check failures.
module latch_test_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned NVEC   = 16,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       p_e,
  output logic       p_d,
  output logic       n_e,
  output logic       n_d,
  input  logic       p_q,
  input  logic       n_q,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_vec,
  output logic [3:0] fail_flags
);

  localparam int unsigned   CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NVEC - 1);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_CLOSE, S_HOLD, S_NEXT, S_DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    lfsr_q;
  logic [7:0]    idx_q;
  logic          p_e_q, p_d_q, n_e_q, n_d_q;
  logic          busy_q, done_q, pass_q;
  logic [7:0]    err_q, fail_vec_q;
  logic [3:0]    fail_flags_q;

  logic          phase_end;
  logic [3:0]    fail_now;
  logic [2:0]    nfail;
  logic [8:0]    err_sum;
  logic [7:0]    err_d;
  logic [7:0]    lfsr_d;

  always_comb begin
    phase_end = (cnt_q == CNT_LAST);
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    fail_now  = 4'b0000;
    if (state_q == S_OPEN && phase_end)
      fail_now[1:0] = {n_q != lfsr_q[1], p_q != lfsr_q[0]};
    if (state_q == S_HOLD && phase_end)
      fail_now[3:2] = {n_q != lfsr_q[1], p_q != lfsr_q[0]};
    nfail   = {2'b00, fail_now[0]} + {2'b00, fail_now[1]}
            + {2'b00, fail_now[2]} + {2'b00, fail_now[3]};
    err_sum = {1'b0, err_q} + {6'b000000, nfail};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= SEED;
      idx_q        <= 8'd0;
      p_e_q        <= 1'b0;
      p_d_q        <= 1'b0;
      n_e_q        <= 1'b1;
      n_d_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 8'd0;
      fail_vec_q   <= 8'd0;
      fail_flags_q <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Abort discards any check due on this edge but keeps the tallies.
        state_q <= S_IDLE;
        cnt_q   <= '0;
        p_e_q   <= 1'b0;
        p_d_q   <= 1'b0;
        n_e_q   <= 1'b1;
        n_d_q   <= 1'b0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (abort) begin
              pass_q <= 1'b0;
            end else if (start) begin
              err_q        <= 8'd0;
              fail_vec_q   <= 8'd0;
              fail_flags_q <= 4'b0000;
              pass_q       <= 1'b0;
              lfsr_q       <= SEED;
              idx_q        <= 8'd0;
              cnt_q        <= '0;
              busy_q       <= 1'b1;
              state_q      <= S_OPEN;
              p_e_q        <= 1'b1;
              n_e_q        <= 1'b0;
              p_d_q        <= SEED[0];
              n_d_q        <= SEED[1];
            end
          end
          S_OPEN: begin
            if (phase_end) begin
              cnt_q   <= '0;
              state_q <= S_CLOSE;
              p_e_q   <= 1'b0;
              n_e_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_CLOSE: begin
            if (phase_end) begin
              cnt_q   <= '0;
              state_q <= S_HOLD;
              p_d_q   <= ~lfsr_q[0];
              n_d_q   <= ~lfsr_q[1];
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_HOLD: begin
            if (phase_end) begin
              cnt_q   <= '0;
              state_q <= S_NEXT;
              p_d_q   <= 1'b0;
              n_d_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_NEXT: begin
            lfsr_q <= lfsr_d;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_q == 8'd0);
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= S_OPEN;
              p_e_q   <= 1'b1;
              n_e_q   <= 1'b0;
              p_d_q   <= lfsr_d[0];
              n_d_q   <= lfsr_d[1];
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase

        // Flags capture the first failing vector: later checks of that same
        // vector are merged in so both its open and hold failures show up.
        if (|fail_now) begin
          err_q <= err_d;
          if (err_q == 8'd0) begin
            fail_vec_q   <= idx_q;
            fail_flags_q <= fail_now;
          end else if (idx_q == fail_vec_q) begin
            fail_flags_q <= fail_flags_q | fail_now;
          end
        end
      end
    end
  end

  assign p_e        = p_e_q;
  assign p_d        = p_d_q;
  assign n_e        = n_e_q;
  assign n_d        = n_d_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_flags = fail_flags_q;

endmodule

// File: tb/tb_latch_test_sequencer.sv
// Directed bench for latch_test_sequencer with behavioural latch models and
// selectable fault injection on the latch outputs.
module tb_latch_test_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       p_e, p_d, n_e, n_d, p_q, n_q;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_vec;
  logic [3:0] fail_flags;
  logic [1:0] mode;

  logic       start_s, abort_s;
  logic       sp_e, sp_d, sn_e, sn_d, sp_q, sn_q;
  logic       sbusy, sdone, spass;
  logic [7:0] serr, svec;
  logic [3:0] sflags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latch_test_sequencer #(.SETTLE(2), .NVEC(16), .SEED(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .p_e(p_e), .p_d(p_d), .n_e(n_e), .n_d(n_d), .p_q(p_q), .n_q(n_q),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .fail_flags(fail_flags)
  );

  latch_test_sequencer #(.SETTLE(1), .NVEC(255), .SEED(8'hA5)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
    .p_e(sp_e), .p_d(sp_d), .n_e(sn_e), .n_d(sn_d), .p_q(sp_q), .n_q(sn_q),
    .busy(sbusy), .done(sdone), .pass(spass),
    .err_count(serr), .fail_vec(svec), .fail_flags(sflags)
  );

  // Ideal latches; n latch is transparent while its enable is low.
  logic lp = 1'b0, ln = 1'b0, lps = 1'b0, lns = 1'b0;
  always_latch begin
    if (p_e) lp = p_d;
  end
  always_latch begin
    if (!n_e) ln = n_d;
  end
  always_latch begin
    if (sp_e) lps = sp_d;
  end
  always_latch begin
    if (!sn_e) lns = sn_d;
  end

  // mode 0 ideal, 1 p latch always transparent, 2 n_q stuck 1, 3 n_q stuck 0
  always_comb begin
    p_q = lp;
    n_q = ln;
    case (mode)
      2'd1:    p_q = p_d;
      2'd2:    n_q = 1'b1;
      2'd3:    n_q = 1'b0;
      default: ;
    endcase
  end
  assign sp_q = ~lps;
  assign sn_q = ~lns;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " p_e"},        32'(p_e), 32'd0);
    chk({tag, " n_e"},        32'(n_e), 32'd1);
    chk({tag, " p_d"},        32'(p_d), 32'd0);
    chk({tag, " n_d"},        32'(n_d), 32'd0);
    chk({tag, " busy"},       32'(busy), 32'd0);
    chk({tag, " done"},       32'(done), 32'd0);
    chk({tag, " pass"},       32'(pass), 32'd0);
    chk({tag, " err_count"},  32'(err_count), 32'd0);
    chk({tag, " fail_vec"},   32'(fail_vec), 32'd0);
    chk({tag, " fail_flags"}, 32'(fail_flags), 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       mid_start;
    int         cyc;
    logic [7:0] err;
    logic [7:0] vec;
    logic [3:0] flags;
    logic       pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    logic got, seen;

    tbl[0] = '{2'd0, 1'b0, 112, 8'd0,  8'd0, 4'b0000, 1'b1};
    tbl[1] = '{2'd1, 1'b1, 112, 8'd16, 8'd0, 4'b0100, 1'b0};
    tbl[2] = '{2'd2, 1'b0, 112, 8'd12, 8'd0, 4'b1010, 1'b0};
    tbl[3] = '{2'd3, 1'b1, 112, 8'd20, 8'd1, 4'b1010, 1'b0};
    tbl[4] = '{2'd0, 1'b0, 112, 8'd0,  8'd0, 4'b0000, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    start_s = 1'b0; abort_s = 1'b0;
    #12;
    check_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      mode  = tbl[i].mode;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("run%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("run%0d pass clr", i), 32'(pass), 32'd0);
      chk($sformatf("run%0d open en", i), 32'({p_e, n_e}), 32'b10);
      chk($sformatf("run%0d open data", i), 32'({p_d, n_d}), 32'b10);
      n = 0; got = 1'b0;
      while (n < 2000 && !got) begin
        tick();
        n++;
        start = (tbl[i].mid_start && n == 30);
        got = done;
      end
      start = 1'b0;
      chk($sformatf("run%0d cycles", i), 32'(n), 32'(tbl[i].cyc));
      chk($sformatf("run%0d pass", i), 32'(pass), 32'(tbl[i].pass));
      chk($sformatf("run%0d err_count", i), 32'(err_count), 32'(tbl[i].err));
      chk($sformatf("run%0d fail_vec", i), 32'(fail_vec), 32'(tbl[i].vec));
      chk($sformatf("run%0d fail_flags", i), 32'(fail_flags), 32'(tbl[i].flags));
      tick();
      chk($sformatf("run%0d done pulse", i), 32'(done), 32'd0);
      chk($sformatf("run%0d busy after", i), 32'(busy), 32'd0);
      chk($sformatf("run%0d pass held", i), 32'(pass), 32'(tbl[i].pass));
    end

    // Abort partway into vector 2 with n_q stuck high: three failures so far.
    mode  = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort pass clr", 32'(pass), 32'd0);
    repeat (18) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort en", 32'({p_e, n_e}), 32'b01);
    chk("abort done", 32'(done), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort err kept", 32'(err_count), 32'd3);
    chk("abort vec kept", 32'(fail_vec), 32'd0);
    chk("abort flags kept", 32'(fail_flags), 32'b1010);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | done | busy;
    end
    chk("abort stays idle", 32'(seen), 32'd0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", 32'(busy), 32'd0);
    chk("start+abort p_e", 32'(p_e), 32'd0);
    chk("start+abort err kept", 32'(err_count), 32'd3);

    // Asynchronous reset in the middle of a run.
    mode  = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset err", 32'(err_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async reset");
    tick();
    rst_n = 1'b1;
    mode  = 2'd0;
    tick();

    // Saturation: 255 vectors, every check fails.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 0; got = 1'b0;
    while (n < 3000 && !got) begin
      tick();
      n++;
      got = sdone;
    end
    chk("sat cycles", 32'(n), 32'd1020);
    chk("sat err_count", 32'(serr), 32'd255);
    chk("sat fail_flags", 32'(sflags), 32'b1111);
    chk("sat fail_vec", 32'(svec), 32'd0);
    chk("sat pass", 32'(spass), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
